// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table with a two-stage, back-pressurable lookup pipeline.
// The lowest-numbered enabled rule that covers the address wins; a miss returns DefaultAttr.
`timescale 1ns/1ps

module pma_region_table #(
    parameter int unsigned NrRules     = 16,
    parameter int unsigned AddrWidth   = 56,
    parameter logic [2:0]  DefaultAttr = 3'b001,
    localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [2:0]           cfg_attr_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IdxW-1:0]      rsp_idx_o,
    output logic [2:0]           rsp_attr_o
);

    // The end is formed one bit wider so a region may reach exactly 2^AddrWidth.
    function automatic logic regionHit(input logic [AddrWidth-1:0] addr,
                                       input logic [AddrWidth-1:0] base,
                                       input logic [AddrWidth-1:0] len);
        logic [AddrWidth:0] regionEnd;
        regionEnd = {1'b0, base} + {1'b0, len};
        return (len != '0) && (addr >= base) && ({1'b0, addr} < regionEnd);
    endfunction

    function automatic logic [IdxW-1:0] priorityIdx(input logic [NrRules-1:0] vec);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int k = int'(NrRules) - 1; k >= 0; k--) begin
            if (vec[k]) idx = IdxW'(k);
        end
        return idx;
    endfunction

    logic [AddrWidth-1:0] baseTbl [NrRules];
    logic [AddrWidth-1:0] lenTbl  [NrRules];
    logic [2:0]           attrTbl [NrRules];
    logic [NrRules-1:0]   enTbl;
    logic [NrRules-1:0]   lockTbl;

    logic idxInRange;
    logic selLocked;
    logic cfgAccept;

    assign idxInRange = ({1'b0, cfg_idx_i} < (IdxW + 1)'(NrRules));

    always_comb begin
        selLocked = 1'b0;
        for (int k = 0; k < int'(NrRules); k++) begin
            if (cfg_idx_i == IdxW'(k)) selLocked = lockTbl[k];
        end
    end

    assign cfgAccept = cfg_we_i && idxInRange && !selLocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enTbl   <= '0;
            lockTbl <= '0;
            for (int k = 0; k < int'(NrRules); k++) begin
                baseTbl[k] <= '0;
                lenTbl[k]  <= '0;
                attrTbl[k] <= '0;
            end
        end else if (cfgAccept) begin
            for (int k = 0; k < int'(NrRules); k++) begin
                if (cfg_idx_i == IdxW'(k)) begin
                    baseTbl[k] <= cfg_base_i;
                    lenTbl[k]  <= cfg_len_i;
                    attrTbl[k] <= cfg_attr_i;
                    enTbl[k]   <= cfg_en_i;
                    lockTbl[k] <= cfg_lock_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && !cfgAccept;
        end
    end

    logic [NrRules-1:0] matchVec;
    logic [2:0]         winAttr;

    always_comb begin
        matchVec = '0;
        winAttr  = DefaultAttr;
        for (int k = 0; k < int'(NrRules); k++) begin
            matchVec[k] = enTbl[k] && regionHit(req_addr_i, baseTbl[k], lenTbl[k]);
        end
        for (int k = int'(NrRules) - 1; k >= 0; k--) begin
            if (matchVec[k]) winAttr = attrTbl[k];
        end
    end

    logic vld_p1;
    logic vld_p2;
    logic s2Adv;
    logic reqAccept;

    assign s2Adv       = !vld_p2 || rsp_ready_i;
    assign req_ready_o = !vld_p1 || s2Adv;
    assign reqAccept   = req_valid_i && req_ready_o;

    // ---- S1: match vector and winning attributes, snapshotted in the acceptance cycle ----
    logic [NrRules-1:0] match_p1;
    logic [2:0]         attr_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else if (req_ready_o) begin
            vld_p1 <= req_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reqAccept) begin
            match_p1 <= matchVec;
            attr_p1  <= winAttr;
        end
    end

    // ---- S2: priority-encoded result, held while the consumer stalls ----
    logic            hit_p2;
    logic [IdxW-1:0] idx_p2;
    logic [2:0]      attr_p2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p2  <= 1'b0;
            hit_p2  <= 1'b0;
            idx_p2  <= '0;
            attr_p2 <= DefaultAttr;
        end else if (s2Adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                hit_p2  <= |match_p1;
                idx_p2  <= priorityIdx(match_p1);
                attr_p2 <= (|match_p1) ? attr_p1 : DefaultAttr;
            end
        end
    end

    assign rsp_valid_o = vld_p2;
    assign rsp_hit_o   = hit_p2;
    assign rsp_idx_o   = idx_p2;
    assign rsp_attr_o  = attr_p2;

endmodule

// File: tb/tb_pma_region_table.sv
// Bench for pma_region_table: directed lookups with literal expectations plus a
// rule-level reference table and in-order response queue checked every cycle.
`timescale 1ns/1ps

module tb_pma_region_table;

    localparam int NR = 16;
    localparam int AW = 56;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfgWe = 1'b0;
    logic [3:0]    cfgIdx = '0;
    logic [AW-1:0] cfgBase = '0;
    logic [AW-1:0] cfgLen = '0;
    logic [2:0]    cfgAttr = '0;
    logic          cfgEn = 1'b0;
    logic          cfgLock = 1'b0;
    logic          reqValid = 1'b0;
    logic [AW-1:0] reqAddr = '0;
    logic          rspReady = 1'b1;
    logic          cfgErr, reqReady, rspValid, rspHit;
    logic [3:0]    rspIdx;
    logic [2:0]    rspAttr;

    // Small instance used only for out-of-range index rejection.
    logic          u2We = 1'b0;
    logic [2:0]    u2Idx = '0;
    logic          u2Err, u2ReqReady, u2RspValid, u2Hit;
    logic [2:0]    u2RIdx, u2Attr;

    always #5 clk = ~clk;

    pma_region_table #(.NrRules(NR), .AddrWidth(AW), .DefaultAttr(3'b001)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(cfgWe), .cfg_idx_i(cfgIdx), .cfg_base_i(cfgBase), .cfg_len_i(cfgLen),
        .cfg_attr_i(cfgAttr), .cfg_en_i(cfgEn), .cfg_lock_i(cfgLock), .cfg_err_o(cfgErr),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_hit_o(rspHit),
        .rsp_idx_o(rspIdx), .rsp_attr_o(rspAttr)
    );

    pma_region_table #(.NrRules(5), .AddrWidth(16), .DefaultAttr(3'b001)) u2 (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(u2We), .cfg_idx_i(u2Idx), .cfg_base_i(16'h0100), .cfg_len_i(16'h0010),
        .cfg_attr_i(3'b010), .cfg_en_i(1'b1), .cfg_lock_i(1'b0), .cfg_err_o(u2Err),
        .req_valid_i(1'b0), .req_ready_o(u2ReqReady), .req_addr_i(16'h0000),
        .rsp_valid_o(u2RspValid), .rsp_ready_i(1'b1), .rsp_hit_o(u2Hit),
        .rsp_idx_o(u2RIdx), .rsp_attr_o(u2Attr)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        hit;
        logic [3:0]  idx;
        logic [2:0]  attr;
        logic [31:0] acc;
    } exp_t;

    logic [AW-1:0] mBase [NR];
    logic [AW-1:0] mLen  [NR];
    logic [2:0]    mAttr [NR];
    bit            mEn   [NR];
    bit            mLock [NR];
    bit            expErr = 1'b0;
    exp_t          q[$];
    int            edgeCnt = 0;
    bit            stalled = 1'b0;
    logic          svHit;
    logic [3:0]    svIdx;
    logic [2:0]    svAttr;

    function automatic exp_t modelLookup(input logic [AW-1:0] a, input int acc);
        exp_t r;
        r.hit  = 1'b0;
        r.idx  = '0;
        r.attr = 3'b001;
        r.acc  = 32'(acc);
        for (int k = 0; k < NR; k++) begin
            if (mEn[k] && mLen[k] != 0 && a >= mBase[k] && (a - mBase[k]) < mLen[k]) begin
                r.hit  = 1'b1;
                r.idx  = 4'(k);
                r.attr = mAttr[k];
                break;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            expErr  = 1'b0;
            stalled = 1'b0;
            for (int k = 0; k < NR; k++) begin
                mBase[k] = '0; mLen[k] = '0; mAttr[k] = '0; mEn[k] = 1'b0; mLock[k] = 1'b0;
            end
        end else begin
            if (rspValid && rspReady && q.size() > 0) void'(q.pop_front());
            if (reqValid && reqReady) q.push_back(modelLookup(reqAddr, edgeCnt));
            stalled = rspValid && !rspReady;
            svHit = rspHit; svIdx = rspIdx; svAttr = rspAttr;
            if (cfgWe) begin
                expErr = mLock[cfgIdx];
                if (!mLock[cfgIdx]) begin
                    mBase[cfgIdx] = cfgBase; mLen[cfgIdx] = cfgLen; mAttr[cfgIdx] = cfgAttr;
                    mEn[cfgIdx] = cfgEn; mLock[cfgIdx] = cfgLock;
                end
            end else begin
                expErr = 1'b0;
            end
        end
        edgeCnt++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit expValid = (q.size() > 0) && (int'(q[0].acc) + 2 <= edgeCnt);
            chk(rspValid === expValid, "mon rsp_valid", 64'(rspValid), 64'(expValid));
            if (rspValid && q.size() > 0) begin
                chk(rspHit === q[0].hit, "mon rsp_hit", 64'(rspHit), 64'(q[0].hit));
                chk(rspIdx === q[0].idx, "mon rsp_idx", 64'(rspIdx), 64'(q[0].idx));
                chk(rspAttr === q[0].attr, "mon rsp_attr", 64'(rspAttr), 64'(q[0].attr));
            end
            chk(reqReady === (q.size() < 2 || rspReady), "mon req_ready",
                64'(reqReady), 64'(q.size() < 2 || rspReady));
            chk(cfgErr === expErr, "mon cfg_err", 64'(cfgErr), 64'(expErr));
            if (stalled) begin
                chk({rspHit, rspIdx, rspAttr} === {svHit, svIdx, svAttr}, "mon stall stable",
                    64'({rspHit, rspIdx, rspAttr}), 64'({svHit, svIdx, svAttr}));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [2:0] attr, input bit en, input bit lock);
        cfgWe = 1'b1; cfgIdx = 4'(idx); cfgBase = base; cfgLen = len;
        cfgAttr = attr; cfgEn = en; cfgLock = lock;
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic waitRsp(input string nm);
        int n = 0;
        while (!rspValid && n < 20) begin
            tick();
            n++;
        end
        chk(rspValid === 1'b1, {nm, " valid"}, 64'(rspValid), 64'(1));
    endtask

    task automatic lookupExpect(input logic [AW-1:0] a, input bit eHit, input int eIdx,
                                input logic [2:0] eAttr, input string nm);
        int n = 0;
        reqValid = 1'b1; reqAddr = a; rspReady = 1'b1;
        #1;
        while (!reqReady && n < 20) begin
            tick(); #1; n++;
        end
        tick();
        reqValid = 1'b0;
        waitRsp(nm);
        chk(rspHit === eHit, {nm, " hit"}, 64'(rspHit), 64'(eHit));
        chk(rspIdx === 4'(eIdx), {nm, " idx"}, 64'(rspIdx), 64'(eIdx));
        chk(rspAttr === eAttr, {nm, " attr"}, 64'(rspAttr), 64'(eAttr));
        tick();
    endtask

    logic [AW-1:0] bpAddr [8] = '{56'h8000_0000, 56'h8000_0800, 56'h4000_000F, 56'h4000_0010,
                                  56'h8000_0FFF, 56'h8000_07FF, 56'h9000_0000, 56'h4000_0000};
    int            bpIdx  [8] = '{3, 1, 2, 0, 1, 3, 0, 2};
    bit            bpHit  [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
    bit            bpPat  [4] = '{1, 0, 0, 1};
    logic [3:0]    gotIdx [8];
    logic          gotHit [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk(rspValid === 1'b0, "reset rsp_valid", 64'(rspValid), 64'(0));
        chk(rspHit === 1'b0, "reset rsp_hit", 64'(rspHit), 64'(0));
        chk(rspIdx === 4'd0, "reset rsp_idx", 64'(rspIdx), 64'(0));
        chk(rspAttr === 3'b001, "reset rsp_attr", 64'(rspAttr), 64'(1));
        chk(cfgErr === 1'b0, "reset cfg_err", 64'(cfgErr), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk(reqReady === 1'b1, "reset req_ready", 64'(reqReady), 64'(1));

        lookupExpect(56'h8000_0000, 0, 0, 3'b001, "miss after reset");

        // Priority and region boundaries
        cfgWrite(3, 56'h8000_0000, 56'h1000, 3'b110, 1, 0);
        cfgWrite(1, 56'h8000_0800, 56'h0800, 3'b001, 1, 0);
        lookupExpect(56'h8000_0800, 1, 1, 3'b001, "prio overlap");
        lookupExpect(56'h8000_07FF, 1, 3, 3'b110, "prio below");
        lookupExpect(56'h8000_1000, 0, 0, 3'b001, "prio end");
        lookupExpect(56'h8000_0FFF, 1, 1, 3'b001, "prio last byte");

        // Top of address space and zero length
        cfgWrite(0, 56'hFF_FFFF_FFFF_FF00, 56'h100, 3'b010, 1, 0);
        lookupExpect(56'hFF_FFFF_FFFF_FFFF, 1, 0, 3'b010, "top of space");
        lookupExpect(56'hFF_FFFF_FFFF_FEFF, 0, 0, 3'b001, "below top region");
        cfgWrite(0, 56'hFF_FFFF_FFFF_FF00, 56'h0, 3'b010, 1, 0);
        lookupExpect(56'hFF_FFFF_FFFF_FF00, 0, 0, 3'b001, "len zero");

        // Locking
        cfgWrite(2, 56'h4000_0000, 56'h10, 3'b010, 1, 1);
        chk(cfgErr === 1'b0, "lock first write", 64'(cfgErr), 64'(0));
        cfgWrite(2, 56'h5000_0000, 56'h10, 3'b111, 1, 0);
        chk(cfgErr === 1'b1, "locked rewrite err", 64'(cfgErr), 64'(1));
        tick();
        chk(cfgErr === 1'b0, "err one cycle", 64'(cfgErr), 64'(0));
        lookupExpect(56'h4000_0004, 1, 2, 3'b010, "locked kept");
        lookupExpect(56'h5000_0000, 0, 0, 3'b001, "locked not moved");

        // Out-of-range index on a 5-entry table
        u2We = 1'b1; u2Idx = 3'd5; tick();
        chk(u2Err === 1'b1, "idx 5 of 5 err", 64'(u2Err), 64'(1));
        u2Idx = 3'd4; tick();
        chk(u2Err === 1'b0, "idx 4 of 5 ok", 64'(u2Err), 64'(0));
        u2Idx = 3'd7; tick();
        chk(u2Err === 1'b1, "idx 7 of 5 err", 64'(u2Err), 64'(1));
        u2We = 1'b0; tick();
        chk(u2Err === 1'b0, "u2 err clears", 64'(u2Err), 64'(0));

        // Back-pressure: 8 back-to-back lookups, ready pattern 1,0,0,1
        begin
            int sent = 0, got = 0, cyc = 0;
            bit sawStall = 0, acceptNow;
            while (got < 8 && cyc < 100) begin
                rspReady = bpPat[cyc % 4];
                reqValid = (sent < 8);
                reqAddr  = bpAddr[(sent < 8) ? sent : 0];
                #1;
                if (!reqReady) sawStall = 1;
                acceptNow = reqValid && reqReady;
                if (rspValid && rspReady) begin
                    gotIdx[got] = rspIdx;
                    gotHit[got] = rspHit;
                    got++;
                end
                tick();
                if (acceptNow) sent++;
                cyc++;
            end
            reqValid = 1'b0;
            rspReady = 1'b1;
            chk(got == 8, "bp response count", 64'(got), 64'(8));
            chk(sawStall, "bp req_ready fell", 64'(sawStall), 64'(1));
            for (int i = 0; i < 8; i++) begin
                chk(gotIdx[i] === 4'(bpIdx[i]), $sformatf("bp idx %0d", i), 64'(gotIdx[i]), 64'(bpIdx[i]));
                chk(gotHit[i] === bpHit[i], $sformatf("bp hit %0d", i), 64'(gotHit[i]), 64'(bpHit[i]));
            end
        end

        // Write and acceptance in the same cycle
        cfgWrite(0, 56'h1000_0000, 56'h100, 3'b100, 0, 0);
        cfgWe = 1'b1; cfgIdx = 4'd0; cfgBase = 56'h1000_0000; cfgLen = 56'h100;
        cfgAttr = 3'b100; cfgEn = 1'b1; cfgLock = 1'b0;
        reqValid = 1'b1; reqAddr = 56'h1000_0010; rspReady = 1'b1;
        tick();
        cfgWe = 1'b0; reqValid = 1'b0;
        waitRsp("race same cycle");
        chk(rspHit === 1'b0, "race same cycle hit", 64'(rspHit), 64'(0));
        chk(rspAttr === 3'b001, "race same cycle attr", 64'(rspAttr), 64'(1));
        tick();
        lookupExpect(56'h1000_0010, 1, 0, 3'b100, "race next");

        // Reset with two lookups in flight
        rspReady = 1'b0;
        reqValid = 1'b1; reqAddr = 56'h8000_0000; tick();
        reqAddr = 56'h8000_0800; tick();
        reqValid = 1'b0;
        chk(rspValid === 1'b1, "inflight before reset", 64'(rspValid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk(rspValid === 1'b0, "async reset valid", 64'(rspValid), 64'(0));
        rspReady = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(rspValid === 1'b0, "no rsp after reset", 64'(rspValid), 64'(0));
        end

        // Reset cleared the lock on entry 2
        cfgWrite(2, 56'h5000_0000, 56'h10, 3'b111, 1, 0);
        chk(cfgErr === 1'b0, "write after reset", 64'(cfgErr), 64'(0));
        lookupExpect(56'h5000_0000, 1, 2, 3'b111, "unlocked rewrite");
        lookupExpect(56'h4000_0004, 0, 0, 3'b001, "old region gone");

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
